bsg_cfg_shadow_commit: RTL and testbench

- Staging front-end for a configuration register. Software-side writes land in a masked shadow copy.
- A commit request transfers the shadow to the downstream variable-enable register as a single one-cycle enable pulse.
- The pulse is issued only once the consumer reports idle, so the consumer never sees a partially-updated configuration.
- Outputs commit_en_o and commit_data_o drive the downstream register's en_i and data_i directly.

---
 rtl/bsg_cfg_shadow_commit.sv | 182 ++++++++++++++++++
 tb/tb_bsg_cfg_shadow_commit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bsg_cfg_shadow_commit.sv
// bsg_cfg_shadow_commit
// Purpose : staging front-end for a configuration register. Masked writes
//           build a shadow copy. A commit moves the shadow into a downstream
//           register as a single enable pulse, and only while the consumer
//           reports idle.
// Latency : a dirty commit raises commit_en_o 2 cycles after acceptance when
//           idle_i is already high. A clean commit raises commit_done_o
//           1 cycle after acceptance.
// Backpressure: w_ready_o and commit_ready_o are high only in IDLE with
//           discard_i low. While a commit is in flight, both writes and new
//           commits are stalled.
//
// Ports:
//   clk_i, reset_i    clock; asynchronous active-high reset
//   w_v_i/w_data_i/w_mask_i/w_ready_o
//                     masked shadow write (valid/ready)
//   commit_v_i/commit_ready_o
//                     commit request (valid/ready)
//   discard_i         revert the shadow to the committed value
//   idle_i            consumer quiescent; safe to reconfigure
//   commit_en_o/commit_data_o
//                     connect to en_i/data_i of the downstream register
//   commit_done_o     one-cycle pulse when a commit completes
//   commit_err_o      one-cycle pulse when a commit times out
//   shadow_o, committed_o, dirty_o, busy_o
//                     status outputs
module bsg_cfg_shadow_commit #(
  // Instantiators must always set width_p. The default exists only so
  // the module elaborates on its own.
  parameter int                 width_p     = 8,
  parameter logic [width_p-1:0] reset_val_p = '0,
  parameter int                 max_wait_p  = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               w_v_i,
  input  logic [width_p-1:0] w_data_i,
  input  logic [width_p-1:0] w_mask_i,
  output logic               w_ready_o,
  input  logic               commit_v_i,
  output logic               commit_ready_o,
  input  logic               discard_i,
  input  logic               idle_i,
  output logic               commit_en_o,
  output logic [width_p-1:0] commit_data_o,
  output logic               commit_done_o,
  output logic               commit_err_o,
  output logic [width_p-1:0] shadow_o,
  output logic [width_p-1:0] committed_o,
  output logic               dirty_o,
  output logic               busy_o
);

  localparam int CW = (max_wait_p < 1) ? 1 : $clog2(max_wait_p + 1);
  localparam logic [CW-1:0] LIMIT = CW'((max_wait_p > 0) ? (max_wait_p - 1) : 0);
  localparam bit TIMEOUT_EN = (max_wait_p > 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_APPLY = 2'd2
  } state_e;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [width_p-1:0] r_shadow;
  logic [width_p-1:0] r_mirror;
  logic [CW-1:0]      r_cnt;

  logic               w_in_idle;
  logic               w_in_wait;
  logic               w_in_apply;
  logic               w_ready;
  logic               w_wr_fire;
  logic               w_cm_fire;
  logic               w_timeout;
  logic [width_p-1:0] w_shadow_pw;

  assign w_in_idle  = (r_state == S_IDLE);
  assign w_in_wait  = (r_state == S_WAIT);
  assign w_in_apply = (r_state == S_APPLY);

  // Discard takes the cycle, so it blocks writes and commits through ready.
  assign w_ready   = w_in_idle & ~discard_i;
  assign w_wr_fire = w_v_i & w_ready;
  assign w_cm_fire = commit_v_i & w_ready;

  // The commit decision uses this post-write value. A write and a commit in
  // the same cycle therefore behave as if the write came first.
  assign w_shadow_pw = w_wr_fire ? ((r_shadow & ~w_mask_i) | (w_data_i & w_mask_i))
                                 : r_shadow;

  assign w_timeout = TIMEOUT_EN && (r_cnt == LIMIT);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cm_fire) begin
          // A clean commit skips the idle handshake. It still produces
          // done, but it does not produce an enable pulse.
          w_state_nxt = (w_shadow_pw != r_mirror) ? S_WAIT : S_APPLY;
        end
      end
      S_WAIT: begin
        // Priority order: discard, then idle, then timeout.
        if (discard_i) begin
          w_state_nxt = S_IDLE;
        end else if (idle_i) begin
          w_state_nxt = S_APPLY;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_APPLY: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    w_ready_o      = w_ready;
    commit_ready_o = w_ready;
    busy_o         = ~w_in_idle;
    commit_done_o  = w_in_apply;
    commit_en_o    = w_in_apply & dirty_o;
    commit_err_o   = w_in_wait & ~discard_i & ~idle_i & w_timeout;
  end

  // ---------------------------------------------------------------------
  // Shadow, mirror and wait counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_shadow <= reset_val_p;
    end else if (discard_i && !w_in_apply) begin
      r_shadow <= r_mirror;
    end else begin
      r_shadow <= w_shadow_pw;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_mirror <= reset_val_p;
    end else if (w_in_apply) begin
      r_mirror <= r_shadow;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt <= '0;
    end else if (w_in_idle && w_cm_fire) begin
      r_cnt <= '0;
    end else if (TIMEOUT_EN && w_in_wait && !discard_i && !idle_i && !w_timeout) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign shadow_o      = r_shadow;
  assign committed_o   = r_mirror;
  assign commit_data_o = r_shadow;
  assign dirty_o       = (r_shadow != r_mirror);

endmodule

// File: tb/tb_bsg_cfg_shadow_commit.sv
module tb_bsg_cfg_shadow_commit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: default timeout (16)
  logic       wv, cv, dc, id;
  logic [7:0] wd, wm;
  logic       a_wrdy, a_crdy, a_en, a_done, a_err, a_dirty, a_busy;
  logic [7:0] a_data, a_sh, a_cm;

  bsg_cfg_shadow_commit #(.width_p(8), .reset_val_p(8'h00), .max_wait_p(16)) dut_a (
    .clk_i(clk), .reset_i(rst),
    .w_v_i(wv), .w_data_i(wd), .w_mask_i(wm), .w_ready_o(a_wrdy),
    .commit_v_i(cv), .commit_ready_o(a_crdy), .discard_i(dc), .idle_i(id),
    .commit_en_o(a_en), .commit_data_o(a_data), .commit_done_o(a_done),
    .commit_err_o(a_err), .shadow_o(a_sh), .committed_o(a_cm),
    .dirty_o(a_dirty), .busy_o(a_busy)
  );

  // DUT B: short timeout (4)
  logic       b_wv, b_cv, b_dc, b_id;
  logic [7:0] b_wd, b_wm;
  logic       b_wrdy, b_crdy, b_en, b_done, b_err, b_dirty, b_busy;
  logic [7:0] b_data, b_sh, b_cm;

  bsg_cfg_shadow_commit #(.width_p(8), .reset_val_p(8'h00), .max_wait_p(4)) dut_b (
    .clk_i(clk), .reset_i(rst),
    .w_v_i(b_wv), .w_data_i(b_wd), .w_mask_i(b_wm), .w_ready_o(b_wrdy),
    .commit_v_i(b_cv), .commit_ready_o(b_crdy), .discard_i(b_dc), .idle_i(b_id),
    .commit_en_o(b_en), .commit_data_o(b_data), .commit_done_o(b_done),
    .commit_err_o(b_err), .shadow_o(b_sh), .committed_o(b_cm),
    .dirty_o(b_dirty), .busy_o(b_busy)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int a_en_cnt = 0;
  int b_en_cnt = 0;

  always @(posedge clk) begin
    if (a_en === 1'b1) a_en_cnt <= a_en_cnt + 1;
    if (b_en === 1'b1) b_en_cnt <= b_en_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic [7:0] wm;
    logic       cv;
    logic       dc;
    logic       id;
    logic [7:0] e_sh;
    logic [7:0] e_cm;
    logic       e_dirty;
    logic       e_busy;
    logic       e_en;
    logic       e_done;
    logic       e_rdy;
  } vec_t;

  localparam int NV = 22;
  vec_t vt [NV];

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int en_before;
    // Test vectors. Each one is applied for one clock; the outputs are
    // checked just after the clock edge, with the vector's inputs still held.
    //           wv  wd     wm     cv  dc  id   sh     cm     dty bsy en  dn  rdy
    vt[0]  = '{1'b1,8'hAB,8'hF0,1'b0,1'b0,1'b0, 8'hA0,8'h00,1'b1,1'b0,1'b0,1'b0,1'b1};
    vt[1]  = '{1'b0,8'h00,8'h00,1'b1,1'b0,1'b1, 8'hA0,8'h00,1'b1,1'b1,1'b0,1'b0,1'b0};
    vt[2]  = '{1'b0,8'h00,8'h00,1'b0,1'b0,1'b1, 8'hA0,8'h00,1'b1,1'b1,1'b1,1'b1,1'b0};
    vt[3]  = '{1'b0,8'h00,8'h00,1'b0,1'b0,1'b1, 8'hA0,8'hA0,1'b0,1'b0,1'b0,1'b0,1'b1};
    vt[4]  = '{1'b0,8'h00,8'h00,1'b1,1'b0,1'b0, 8'hA0,8'hA0,1'b0,1'b1,1'b0,1'b1,1'b0};
    vt[5]  = '{1'b0,8'h00,8'h00,1'b0,1'b0,1'b0, 8'hA0,8'hA0,1'b0,1'b0,1'b0,1'b0,1'b1};
    vt[6]  = '{1'b1,8'h55,8'hFF,1'b1,1'b0,1'b0, 8'h55,8'hA0,1'b1,1'b1,1'b0,1'b0,1'b0};
    vt[7]  = '{1'b0,8'h00,8'h00,1'b0,1'b0,1'b0, 8'h55,8'hA0,1'b1,1'b1,1'b0,1'b0,1'b0};
    vt[8]  = '{1'b0,8'h00,8'h00,1'b0,1'b0,1'b0, 8'h55,8'hA0,1'b1,1'b1,1'b0,1'b0,1'b0};
    vt[9]  = '{1'b0,8'h00,8'h00,1'b0,1'b0,1'b0, 8'h55,8'hA0,1'b1,1'b1,1'b0,1'b0,1'b0};
    vt[10] = '{1'b0,8'h00,8'h00,1'b0,1'b0,1'b0, 8'h55,8'hA0,1'b1,1'b1,1'b0,1'b0,1'b0};
    vt[11] = '{1'b0,8'h00,8'h00,1'b0,1'b0,1'b1, 8'h55,8'hA0,1'b1,1'b1,1'b1,1'b1,1'b0};
    vt[12] = '{1'b0,8'h00,8'h00,1'b0,1'b0,1'b0, 8'h55,8'h55,1'b0,1'b0,1'b0,1'b0,1'b1};
    vt[13] = '{1'b1,8'h11,8'hFF,1'b1,1'b0,1'b1, 8'h11,8'h55,1'b1,1'b1,1'b0,1'b0,1'b0};
    vt[14] = '{1'b0,8'h00,8'h00,1'b0,1'b0,1'b1, 8'h11,8'h55,1'b1,1'b1,1'b1,1'b1,1'b0};
    vt[15] = '{1'b0,8'h00,8'h00,1'b0,1'b0,1'b0, 8'h11,8'h11,1'b0,1'b0,1'b0,1'b0,1'b1};
    vt[16] = '{1'b1,8'h33,8'hFF,1'b1,1'b0,1'b0, 8'h33,8'h11,1'b1,1'b1,1'b0,1'b0,1'b0};
    vt[17] = '{1'b0,8'h00,8'h00,1'b0,1'b1,1'b1, 8'h11,8'h11,1'b0,1'b0,1'b0,1'b0,1'b0};
    vt[18] = '{1'b0,8'h00,8'h00,1'b0,1'b0,1'b0, 8'h11,8'h11,1'b0,1'b0,1'b0,1'b0,1'b1};
    vt[19] = '{1'b1,8'h0F,8'h0F,1'b0,1'b0,1'b0, 8'h1F,8'h11,1'b1,1'b0,1'b0,1'b0,1'b1};
    vt[20] = '{1'b1,8'hFF,8'hFF,1'b1,1'b1,1'b0, 8'h11,8'h11,1'b0,1'b0,1'b0,1'b0,1'b0};
    vt[21] = '{1'b1,8'hFF,8'h00,1'b0,1'b0,1'b0, 8'h11,8'h11,1'b0,1'b0,1'b0,1'b0,1'b1};

    wv = 0; wd = 0; wm = 0; cv = 0; dc = 0; id = 0;
    b_wv = 0; b_wd = 0; b_wm = 0; b_cv = 0; b_dc = 0; b_id = 0;

    // Reset state
    #3;
    chk("reset shadow", a_sh, 8'h00);
    chk("reset committed", a_cm, 8'h00);
    chk("reset dirty", a_dirty, 1'b0);
    chk("reset w_ready", a_wrdy, 1'b1);
    chk("reset commit_ready", a_crdy, 1'b1);
    chk("reset busy", a_busy, 1'b0);
    chk("reset en", a_en, 1'b0);
    chk("reset done", a_done, 1'b0);
    chk("reset err", a_err, 1'b0);
    @(negedge clk);
    rst = 0;

    // Timeout on DUT B: dirty commit with idle_i held low
    @(negedge clk);
    b_wv = 1; b_wd = 8'h3C; b_wm = 8'hFF; b_cv = 1; b_id = 0;
    @(posedge clk); #1;
    @(negedge clk);
    b_wv = 0; b_cv = 0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      chk($sformatf("timeout wait%0d busy", k), b_busy, 1'b1);
      chk($sformatf("timeout wait%0d err", k), b_err, (k == 4) ? 1'b1 : 1'b0);
    end
    @(posedge clk); #1;
    chk("timeout idle busy", b_busy, 1'b0);
    chk("timeout still dirty", b_dirty, 1'b1);
    chk("timeout shadow kept", b_sh, 8'h3C);
    chk("timeout err one pulse", b_err, 1'b0);
    chk("timeout committed", b_cm, 8'h00);
    chk("timeout no en", b_en_cnt, 0);

    // Table-driven vectors on DUT A
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      wv = vt[i].wv; wd = vt[i].wd; wm = vt[i].wm;
      cv = vt[i].cv; dc = vt[i].dc; id = vt[i].id;
      @(posedge clk); #1;
      chk($sformatf("v%0d shadow", i), a_sh, vt[i].e_sh);
      chk($sformatf("v%0d committed", i), a_cm, vt[i].e_cm);
      chk($sformatf("v%0d dirty", i), a_dirty, vt[i].e_dirty);
      chk($sformatf("v%0d busy", i), a_busy, vt[i].e_busy);
      chk($sformatf("v%0d en", i), a_en, vt[i].e_en);
      chk($sformatf("v%0d done", i), a_done, vt[i].e_done);
      chk($sformatf("v%0d w_ready", i), a_wrdy, vt[i].e_rdy);
      chk($sformatf("v%0d commit_ready", i), a_crdy, vt[i].e_rdy);
      chk($sformatf("v%0d data", i), a_data, vt[i].e_sh);
      chk($sformatf("v%0d err", i), a_err, 1'b0);
    end

    // Reset asserted in the middle of WAIT
    @(negedge clk);
    wv = 1; wd = 8'h77; wm = 8'hFF; cv = 1; dc = 0; id = 0;
    @(posedge clk); #1;
    chk("midreset in wait", a_busy, 1'b1);
    en_before = a_en_cnt;
    #2 rst = 1;
    #1;
    chk("midreset shadow", a_sh, 8'h00);
    chk("midreset committed", a_cm, 8'h00);
    chk("midreset busy", a_busy, 1'b0);
    chk("midreset en", a_en, 1'b0);
    chk("midreset done", a_done, 1'b0);
    @(negedge clk);
    rst = 0; wv = 0; cv = 0; id = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("midreset no en after", a_en_cnt - en_before, 0);
    chk("midreset idle", a_busy, 1'b0);
    chk("midreset dirty", a_dirty, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
